// File: rtl/device_pkt_decoder.sv
// Serial packet decoder: SYNC / PID / token / data field extraction with end-of-packet validation.
// Optional build macro DEVICE_PKT_CRC_CHECK_EN enables CRC5/CRC16 residual checking.
module device_pkt_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        inb,
    input  logic        in_valid,
    input  logic        eop,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        pkt_valid,
    output logic        error,
    output logic        busy
);

    // state    | meaning
    // IDLE     | waiting for the first bit of a packet
    // SYNC     | checking the 8-bit sync pattern 0000_0001
    // PID      | collecting the PID byte, LSB first
    // TOKEN    | collecting addr/endp/CRC5 (16 bits)
    // DATA     | collecting 64-bit payload plus CRC16 (80 bits)
    // WAIT_EOP | packet complete, waiting for eop
    // ERR      | packet rejected, discarding bits until eop
    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_TOKEN, ST_DATA, ST_WAIT_EOP, ST_ERR
    } state_t;

    state_t      state_q;
    logic [6:0]  bit_cnt_q;
    logic [7:0]  pid_sr_q;
    logic [10:0] tok_sr_q;
    logic [63:0] data_sr_q;
    logic [3:0]  pid_q;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic [63:0] data_q;
    logic        pkt_valid_q;
    logic        error_q;

    logic [7:0]  pid_byte_d;
    logic        nibble_ok;
    logic        crc_ok;

    assign pid_byte_d = {inb, pid_sr_q[7:1]};
    assign nibble_ok  = (pid_byte_d[7:4] == ~pid_byte_d[3:0]);

`ifdef DEVICE_PKT_CRC_CHECK_EN
    logic [4:0]  crc5_q;
    logic [4:0]  crc5_d;
    logic [15:0] crc16_q;
    logic [15:0] crc16_d;

    assign crc5_d  = {crc5_q[3:0], 1'b0} ^ ({5{inb ^ crc5_q[4]}} & 5'h05);
    assign crc16_d = {crc16_q[14:0], 1'b0} ^ ({16{inb ^ crc16_q[15]}} & 16'h8005);

    // PID bits [1:0] distinguish token (01), data (11) and handshake (10)
    always_comb begin
        crc_ok = 1'b1;
        case (pid_sr_q[1:0])
            2'b01:   crc_ok = (crc5_q == 5'b01100);
            2'b11:   crc_ok = (crc16_q == 16'h800D);
            default: crc_ok = 1'b1;
        endcase
    end
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            pid_sr_q    <= '0;
            tok_sr_q    <= '0;
            data_sr_q   <= '0;
            pid_q       <= '0;
            addr_q      <= '0;
            endp_q      <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            error_q     <= 1'b0;
`ifdef DEVICE_PKT_CRC_CHECK_EN
            crc5_q      <= '0;
            crc16_q     <= '0;
`endif
        end else begin
            pkt_valid_q <= 1'b0;
            error_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !eop) begin
                        bit_cnt_q <= 7'd1;
                        state_q   <= inb ? ST_ERR : ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (eop) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        if (inb != (bit_cnt_q == 7'd7)) begin
                            state_q <= ST_ERR;
                        end else if (bit_cnt_q == 7'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_PID;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                end
                ST_PID: begin
                    if (eop) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        pid_sr_q <= pid_byte_d;
                        if (bit_cnt_q == 7'd7) begin
                            bit_cnt_q <= '0;
`ifdef DEVICE_PKT_CRC_CHECK_EN
                            crc5_q    <= 5'h1F;
                            crc16_q   <= 16'hFFFF;
`endif
                            if (!nibble_ok) begin
                                state_q <= ST_ERR;
                            end else begin
                                case (pid_byte_d[3:0])
                                    4'b0001, 4'b1001, 4'b1101: state_q <= ST_TOKEN;
                                    4'b0011, 4'b1011:          state_q <= ST_DATA;
                                    4'b0010, 4'b1010:          state_q <= ST_WAIT_EOP;
                                    default:                   state_q <= ST_ERR;
                                endcase
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                end
                ST_TOKEN: begin
                    if (eop) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        if (bit_cnt_q < 7'd11) begin
                            tok_sr_q <= {inb, tok_sr_q[10:1]};
                        end
`ifdef DEVICE_PKT_CRC_CHECK_EN
                        crc5_q <= crc5_d;
`endif
                        if (bit_cnt_q == 7'd15) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_WAIT_EOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (eop) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        if (bit_cnt_q < 7'd64) begin
                            data_sr_q <= {inb, data_sr_q[63:1]};
                        end
`ifdef DEVICE_PKT_CRC_CHECK_EN
                        crc16_q <= crc16_d;
`endif
                        if (bit_cnt_q == 7'd79) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_WAIT_EOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                end
                ST_WAIT_EOP: begin
                    if (eop) begin
                        state_q <= ST_IDLE;
                        if (crc_ok) begin
                            pkt_valid_q <= 1'b1;
                            pid_q       <= pid_sr_q[3:0];
                            if (pid_sr_q[1:0] == 2'b01) begin
                                addr_q <= tok_sr_q[6:0];
                                endp_q <= tok_sr_q[10:7];
                            end
                            if (pid_sr_q[1:0] == 2'b11) begin
                                data_q <= data_sr_q;
                            end
                        end else begin
                            error_q <= 1'b1;
                        end
                    end else if (in_valid) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (eop) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pid       = pid_q;
    assign addr      = addr_q;
    assign endp      = endp_q;
    assign data      = data_q;
    assign pkt_valid = pkt_valid_q;
    assign error     = error_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_device_pkt_decoder.sv
// Directed bench for device_pkt_decoder; expectations follow DEVICE_PKT_CRC_CHECK_EN when defined.
module tb_device_pkt_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inb;
    logic        in_valid;
    logic        eop;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        pkt_valid;
    logic        error;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    device_pkt_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .inb       (inb),
        .in_valid  (in_valid),
        .eop       (eop),
        .pid       (pid),
        .addr      (addr),
        .endp      (endp),
        .data      (data),
        .pkt_valid (pkt_valid),
        .error     (error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic send_bit(input logic b);
        inb      = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        inb      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_sync();
        send_byte(8'h80);
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
    endtask

    function automatic logic [4:0] crc5_of(input logic [10:0] m);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (m[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_of(input logic [63:0] m);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            if (m[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Bit k of the returned vector is the k-th bit on the line.
    function automatic logic [15:0] token_stream(input logic [6:0] a, input logic [3:0] e,
                                                 input logic [4:0] crc_xor);
        logic [15:0] s;
        logic [4:0]  c;
        s[10:0] = {e, a};
        c = crc5_of({e, a}) ^ crc_xor;
        for (int j = 0; j < 5; j++) s[11 + j] = ~c[4 - j];
        return s;
    endfunction

    function automatic logic [79:0] data_stream(input logic [63:0] sent, input logic [63:0] crc_src);
        logic [79:0] s;
        logic [15:0] c;
        s[63:0] = sent;
        c = crc16_of(crc_src);
        for (int j = 0; j < 16; j++) s[64 + j] = ~c[15 - j];
        return s;
    endfunction

    logic [15:0] tok_s;
    logic [79:0] dat_s;
    logic [63:0] exp_data;
    logic [3:0]  exp_pid;
    localparam logic [63:0] PAYLOAD = 64'h0123456789ABCDEF;

    initial begin
        rst = 1'b1; inb = 1'b0; in_valid = 1'b0; eop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pid", pid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_endp", endp, 0);
        chk("rst_data", data, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // OUT token, addr 05, endp 3
        send_sync();
        chk("out_busy_after_sync", busy, 1);
        send_byte(8'hE1);
        tok_s = token_stream(7'h05, 4'h3, 5'h00);
        for (int i = 0; i < 16; i++) send_bit(tok_s[i]);
        chk("out_busy_wait_eop", busy, 1);
        chk("out_no_early_valid", pkt_valid, 0);
        pulse_eop();
        chk("out_pkt_valid", pkt_valid, 1);
        chk("out_error", error, 0);
        chk("out_pid", pid, 4'h1);
        chk("out_addr", addr, 7'h05);
        chk("out_endp", endp, 4'h3);
        @(negedge clk);
        chk("out_pulse_one_cycle", pkt_valid, 0);
        chk("out_busy_idle", busy, 0);

        // DATA0 with correct CRC16
        send_sync();
        send_byte(8'hC3);
        dat_s = data_stream(PAYLOAD, PAYLOAD);
        for (int i = 0; i < 80; i++) send_bit(dat_s[i]);
        pulse_eop();
        chk("d0_pkt_valid", pkt_valid, 1);
        chk("d0_error", error, 0);
        chk("d0_pid", pid, 4'h3);
        chk("d0_data", data, PAYLOAD);
        chk("d0_addr_hold", addr, 7'h05);
        chk("d0_endp_hold", endp, 4'h3);
        @(negedge clk);

        // DATA1 with payload bit 0 flipped, CRC of the original payload
        send_sync();
        send_byte(8'h4B);
        dat_s = data_stream(PAYLOAD ^ 64'h1, PAYLOAD);
        for (int i = 0; i < 80; i++) send_bit(dat_s[i]);
        pulse_eop();
`ifdef DEVICE_PKT_CRC_CHECK_EN
        exp_data = PAYLOAD;
        exp_pid  = 4'h3;
        chk("d1bad_error", error, 1);
        chk("d1bad_pkt_valid", pkt_valid, 0);
`else
        exp_data = PAYLOAD ^ 64'h1;
        exp_pid  = 4'hB;
        chk("d1bad_error", error, 0);
        chk("d1bad_pkt_valid", pkt_valid, 1);
`endif
        chk("d1bad_data", data, exp_data);
        chk("d1bad_pid", pid, exp_pid);
        @(negedge clk);

        // ACK: pid changes, token/data fields hold
        send_sync();
        send_byte(8'hD2);
        pulse_eop();
        chk("ack_pkt_valid", pkt_valid, 1);
        chk("ack_pid", pid, 4'h2);
        chk("ack_addr_hold", addr, 7'h05);
        chk("ack_endp_hold", endp, 4'h3);
        chk("ack_data_hold", data, exp_data);
        @(negedge clk);

        // ACK followed by an extra bit: overlength
        send_sync();
        send_byte(8'hD2);
        send_bit(1'b0);
        chk("ack_long_busy", busy, 1);
        pulse_eop();
        chk("ack_long_error", error, 1);
        chk("ack_long_pkt_valid", pkt_valid, 0);
        @(negedge clk);

        // PID with bad check nibble: rest discarded until eop
        send_sync();
        send_byte(8'h11);
        chk("badpid_busy_a", busy, 1);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk("badpid_busy_b", busy, 1);
        chk("badpid_no_early_err", error, 0);
        pulse_eop();
        chk("badpid_error", error, 1);
        chk("badpid_pkt_valid", pkt_valid, 0);
        chk("badpid_pid_hold", pid, 4'h2);
        @(negedge clk);
        chk("badpid_error_one_cycle", error, 0);
        chk("badpid_busy_idle", busy, 0);

        // Short token: eop after 10 bits
        send_sync();
        send_byte(8'hE1);
        tok_s = token_stream(7'h12, 4'h6, 5'h00);
        for (int i = 0; i < 10; i++) send_bit(tok_s[i]);
        pulse_eop();
        chk("short_tok_error", error, 1);
        chk("short_tok_pkt_valid", pkt_valid, 0);
        chk("short_tok_addr_hold", addr, 7'h05);
        @(negedge clk);

        // eop coincides with the last token bit: eop wins, bit dropped
        send_sync();
        send_byte(8'hE1);
        for (int i = 0; i < 15; i++) send_bit(tok_s[i]);
        inb = tok_s[15]; in_valid = 1'b1; eop = 1'b1;
        @(negedge clk);
        inb = 1'b0; in_valid = 1'b0; eop = 1'b0;
        chk("coinc_error", error, 1);
        chk("coinc_pkt_valid", pkt_valid, 0);
        chk("coinc_addr_hold", addr, 7'h05);
        @(negedge clk);
        chk("coinc_busy_idle", busy, 0);

        // eop in IDLE is ignored
        pulse_eop();
        chk("idle_eop_error", error, 0);
        chk("idle_eop_pkt_valid", pkt_valid, 0);
        chk("idle_eop_busy", busy, 0);

`ifdef DEVICE_PKT_CRC_CHECK_EN
        send_sync();
        send_byte(8'hE1);
        tok_s = token_stream(7'h12, 4'h6, 5'h01);
        for (int i = 0; i < 16; i++) send_bit(tok_s[i]);
        pulse_eop();
        chk("badcrc5_error", error, 1);
        chk("badcrc5_addr_hold", addr, 7'h05);
        @(negedge clk);
`endif

        // Reset at DATA bit 40, then a full IN token
        send_sync();
        send_byte(8'hC3);
        dat_s = data_stream(PAYLOAD, PAYLOAD);
        for (int i = 0; i < 40; i++) send_bit(dat_s[i]);
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pid", pid, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_endp", endp, 0);
        chk("midrst_data", data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pkt_valid", pkt_valid, 0);
        chk("midrst_error", error, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_pulse_v", pkt_valid, 0);
        chk("midrst_no_pulse_e", error, 0);

        send_sync();
        send_byte(8'h69);
        tok_s = token_stream(7'h2A, 4'hC, 5'h00);
        for (int i = 0; i < 16; i++) send_bit(tok_s[i]);
        pulse_eop();
        chk("in_pkt_valid", pkt_valid, 1);
        chk("in_error", error, 0);
        chk("in_pid", pid, 4'h9);
        chk("in_addr", addr, 7'h2A);
        chk("in_endp", endp, 4'hC);
        chk("in_data_zero", data, 0);
        @(negedge clk);
        chk("in_pulse_one_cycle", pkt_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
